// File: rtl/arcade_input_mapper_if.sv
// arcade_input_mapper_if: joystick words and routing controls coming from the
// hps_io side, plus the debounced player/system controls going back to the
// core. The master is the hps_io side; the slave is the mapper.
interface arcade_input_mapper_if #(
    parameter int NUM_PLAYERS = 2
);
    logic [16*NUM_PLAYERS-1:0] joy_in;
    logic                      share_mode;
    logic                      swap_12;
    logic [NUM_PLAYERS-1:0]    p_left;
    logic [NUM_PLAYERS-1:0]    p_right;
    logic [NUM_PLAYERS-1:0]    p_flap;
    logic                      start1;
    logic                      start2;
    logic                      pause;
    logic                      coin;

    modport master (
        output joy_in, share_mode, swap_12,
        input  p_left, p_right, p_flap, start1, start2, pause, coin
    );

    modport slave (
        input  joy_in, share_mode, swap_12,
        output p_left, p_right, p_flap, start1, start2, pause, coin
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: routes hps_io joystick words to players (shared or
// cocktail-swapped), debounces every routed control bit independently,
// cancels opposing left/right, and turns the coin button into one
// fixed-width pulse per press.
// Optional feature: define ARCADE_INPUT_AUTOFIRE_EN to let joystick bit 9
// add a square wave onto each player's flap output.
module arcade_input_mapper #(
    parameter int NUM_PLAYERS       = 2,
    parameter int DEB_CYCLES        = 12000,
    parameter int COIN_PULSE_CYCLES = 600000,
    parameter int AUTOFIRE_HALF     = 600000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    arcade_input_mapper_if.slave bus
);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int PB = 4;
`else
    localparam int PB = 3;
`endif
    localparam int GB       = NUM_PLAYERS * PB;
    localparam int NUM_DEB  = GB + 4;
    localparam int DW       = $clog2(DEB_CYCLES + 1);
    localparam int CW       = $clog2(COIN_PULSE_CYCLES + 1);
    localparam int SWAP_IDX = (NUM_PLAYERS > 1) ? 1 : 0;

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_WAIT_REL
    } coin_state_t;

    logic [15:0]            joy_or;
    logic [15:0]            routed [NUM_PLAYERS];
    logic                   unused_route;
    logic [NUM_DEB-1:0]     deb_raw;
    logic [NUM_DEB-1:0]     deb_state;
    logic [DW-1:0]          deb_cnt [NUM_DEB];
    logic [NUM_PLAYERS-1:0] p_left_q, p_right_q, p_flap_q;
    logic                   start1_q, start2_q, pause_q, coin_q;
    coin_state_t            coin_state;
    logic [CW-1:0]          coin_cnt;

    // OR of every joystick word: feeds share mode and the system buttons
    always_comb begin
        joy_or = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            joy_or = joy_or | bus.joy_in[16*p +: 16];
        end
    end

    // Player routing ahead of the debouncers, so mode changes are filtered too
    always_comb begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            routed[p] = bus.joy_in[16*p +: 16];
        end
        if (bus.share_mode) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                routed[p] = joy_or;
            end
        end else if (bus.swap_12 && (NUM_PLAYERS > 1)) begin
            routed[0]        = bus.joy_in[16*SWAP_IDX +: 16];
            routed[SWAP_IDX] = bus.joy_in[15:0];
        end
    end

    // Collects the joystick bits this mapper has no use for
    always_comb begin
        unused_route = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            unused_route = unused_route ^ (^routed[p]);
        end
    end

    // Raw debouncer inputs: per player right/left/flap(/autofire), then start1, start2, pause, coin
    always_comb begin
        deb_raw = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            deb_raw[PB*p + 0] = routed[p][0];
            deb_raw[PB*p + 1] = routed[p][1];
            deb_raw[PB*p + 2] = routed[p][4];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            deb_raw[PB*p + 3] = routed[p][9];
`endif
        end
        deb_raw[GB + 0] = joy_or[5];
        deb_raw[GB + 1] = joy_or[6];
        deb_raw[GB + 2] = joy_or[8];
        deb_raw[GB + 3] = joy_or[7];
    end

    // Independent debouncers: accept a new level only after DEB_CYCLES stable cycles
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            deb_state <= '0;
            for (int i = 0; i < NUM_DEB; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DEB; i++) begin
                if (deb_raw[i] == deb_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] >= DW'(DEB_CYCLES - 1)) begin
                    deb_state[i] <= deb_raw[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_HALF + 1);
    logic [AW-1:0] af_cnt;
    logic          af_phase;
    logic          af_any;

    // Autofire is live while any player's debounced autofire bit is held
    always_comb begin
        af_any = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            af_any = af_any | deb_state[PB*p + 3];
        end
    end

    // Shared half-period counter; idle keeps phase 0 so the wave starts high
    always_ff @(posedge clk_sys) begin
        if (reset || !af_any) begin
            af_cnt   <= '0;
            af_phase <= 1'b0;
        end else if (af_cnt >= AW'(AUTOFIRE_HALF - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + AW'(1);
        end
    end
`endif

    // Registered player/system outputs with left/right cancellation
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            p_left_q  <= '0;
            p_right_q <= '0;
            p_flap_q  <= '0;
            start1_q  <= 1'b0;
            start2_q  <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                p_right_q[p] <= deb_state[PB*p + 0] & ~deb_state[PB*p + 1];
                p_left_q[p]  <= deb_state[PB*p + 1] & ~deb_state[PB*p + 0];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
                p_flap_q[p]  <= deb_state[PB*p + 2] | (deb_state[PB*p + 3] & ~af_phase);
`else
                p_flap_q[p]  <= deb_state[PB*p + 2];
`endif
            end
            start1_q <= deb_state[GB + 0];
            start2_q <= deb_state[GB + 1];
            pause_q  <= deb_state[GB + 2];
        end
    end

    // Coin FSM: IDLE is only entered with coin released, so a high level there is a fresh press
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_state <= COIN_IDLE;
            coin_cnt   <= '0;
            coin_q     <= 1'b0;
        end else begin
            case (coin_state)
                COIN_IDLE: begin
                    if (deb_state[GB + 3]) begin
                        coin_state <= COIN_PULSE;
                        coin_cnt   <= '0;
                        coin_q     <= 1'b1;
                    end
                end
                COIN_PULSE: begin
                    if (coin_cnt >= CW'(COIN_PULSE_CYCLES - 1)) begin
                        coin_cnt   <= '0;
                        coin_q     <= 1'b0;
                        coin_state <= deb_state[GB + 3] ? COIN_WAIT_REL : COIN_IDLE;
                    end else begin
                        coin_cnt <= coin_cnt + CW'(1);
                    end
                end
                COIN_WAIT_REL: begin
                    if (!deb_state[GB + 3]) begin
                        coin_state <= COIN_IDLE;
                    end
                end
                default: begin
                    coin_state <= COIN_IDLE;
                    coin_cnt   <= '0;
                    coin_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p_left  = p_left_q;
    assign bus.p_right = p_right_q;
    assign bus.p_flap  = p_flap_q;
    assign bus.start1  = start1_q;
    assign bus.start2  = start2_q;
    assign bus.pause   = pause_q;
    assign bus.coin    = coin_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of routing, debounce latency and
// glitch rejection, left/right cancellation, coin pulse generation, reset
// behaviour and the autofire option (whichever way the macro is set).
module tb_arcade_input_mapper;

    localparam int NP = 2;

    logic clk_sys = 1'b0;
    logic reset   = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    arcade_input_mapper_if #(.NUM_PLAYERS(NP)) bus ();

    arcade_input_mapper #(
        .NUM_PLAYERS      (NP),
        .DEB_CYCLES       (4),
        .COIN_PULSE_CYCLES(10),
        .AUTOFIRE_HALF    (8)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance n rising edges and settle 1ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic clear_inputs(input int settle);
        bus.joy_in     = '0;
        bus.share_mode = 1'b0;
        bus.swap_12    = 1'b0;
        tick(settle);
    endtask

    task automatic test_reset;
        bus.joy_in     = '0;
        bus.share_mode = 1'b0;
        bus.swap_12    = 1'b0;
        reset = 1'b1;
        tick(2);
        tests_run++;
        if (bus.p_left !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_p_left got %b want 00", bus.p_left); end
        tests_run++;
        if (bus.p_right !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_p_right got %b want 00", bus.p_right); end
        tests_run++;
        if (bus.p_flap !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_p_flap got %b want 00", bus.p_flap); end
        tests_run++;
        if ({bus.start1, bus.start2, bus.pause, bus.coin} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_system got %b want 0000", {bus.start1, bus.start2, bus.pause, bus.coin});
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_debounce;
        clear_inputs(8);
        bus.joy_in[0] = 1'b1;
        tick(4);
        tests_run++;
        if (bus.p_right[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL right_early got %b want 0", bus.p_right[0]); end
        tick(1);
        tests_run++;
        if (bus.p_right[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL right_rise got %b want 1", bus.p_right[0]); end
        bus.joy_in[0] = 1'b0;
        tick(6);
        tests_run++;
        if (bus.p_right[0] !== 1'b0) begin tests_failed++; $display("[TB] FAIL right_release got %b want 0", bus.p_right[0]); end
        bus.joy_in[1] = 1'b1;
        tick(3);
        bus.joy_in[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            tests_run++;
            if (bus.p_left[0] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL glitch_left cycle %0d got %b want 0", k, bus.p_left[0]);
            end
        end
    endtask

    task automatic test_global_buttons;
        clear_inputs(8);
        bus.joy_in[16+5] = 1'b1;
        bus.joy_in[8]    = 1'b1;
        tick(4);
        tests_run++;
        if ({bus.start1, bus.pause} !== 2'b00) begin tests_failed++; $display("[TB] FAIL sys_early got %b want 00", {bus.start1, bus.pause}); end
        tick(1);
        tests_run++;
        if ({bus.start1, bus.start2, bus.pause} !== 3'b101) begin
            tests_failed++;
            $display("[TB] FAIL sys_rise got %b want 101", {bus.start1, bus.start2, bus.pause});
        end
    endtask

    task automatic test_routing;
        clear_inputs(8);
        bus.share_mode   = 1'b1;
        bus.joy_in[16+4] = 1'b1;
        tick(6);
        tests_run++;
        if (bus.p_flap !== 2'b11) begin tests_failed++; $display("[TB] FAIL route_share got %b want 11", bus.p_flap); end
        bus.share_mode = 1'b0;
        bus.swap_12    = 1'b1;
        tick(6);
        tests_run++;
        if (bus.p_flap !== 2'b01) begin tests_failed++; $display("[TB] FAIL route_swap got %b want 01", bus.p_flap); end
        bus.swap_12 = 1'b0;
        tick(6);
        tests_run++;
        if (bus.p_flap !== 2'b10) begin tests_failed++; $display("[TB] FAIL route_direct got %b want 10", bus.p_flap); end
    endtask

    task automatic test_cancel;
        clear_inputs(8);
        bus.joy_in[16] = 1'b1;
        bus.joy_in[17] = 1'b1;
        tick(6);
        tests_run++;
        if ({bus.p_left[1], bus.p_right[1]} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL cancel_both got %b want 00", {bus.p_left[1], bus.p_right[1]});
        end
        bus.joy_in[16] = 1'b0;
        tick(4);
        tests_run++;
        if (bus.p_left[1] !== 1'b0) begin tests_failed++; $display("[TB] FAIL cancel_early got %b want 0", bus.p_left[1]); end
        tick(1);
        tests_run++;
        if ({bus.p_left[1], bus.p_right[1]} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL cancel_left got %b want 10", {bus.p_left[1], bus.p_right[1]});
        end
    endtask

    task automatic test_coin;
        int highs;
        logic exp;
        clear_inputs(12);
        highs = 0;
        bus.joy_in[7] = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick(1);
            exp = (k >= 5) && (k <= 14);
            if (bus.coin === 1'b1) highs++;
            tests_run++;
            if (bus.coin !== exp) begin
                tests_failed++;
                $display("[TB] FAIL coin_held cycle %0d got %b want %b", k, bus.coin, exp);
            end
        end
        tests_run++;
        if (highs != 10) begin tests_failed++; $display("[TB] FAIL coin_width got %0d want 10", highs); end
        bus.joy_in[7] = 1'b0;
        tick(12);
        bus.joy_in[7] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            exp = (k >= 5) && (k <= 14);
            tests_run++;
            if (bus.coin !== exp) begin
                tests_failed++;
                $display("[TB] FAIL coin_repress cycle %0d got %b want %b", k, bus.coin, exp);
            end
        end
    endtask

    task automatic test_reset_mid_pulse;
        logic exp;
        clear_inputs(12);
        bus.joy_in[7] = 1'b1;
        bus.joy_in[0] = 1'b1;
        tick(5);
        tests_run++;
        if ({bus.coin, bus.p_right[0]} !== 2'b11) begin
            tests_failed++;
            $display("[TB] FAIL midpulse_pre got %b want 11", {bus.coin, bus.p_right[0]});
        end
        tick(2);
        reset = 1'b1;
        tick(1);
        tests_run++;
        if (bus.coin !== 1'b0) begin tests_failed++; $display("[TB] FAIL midpulse_coin got %b want 0", bus.coin); end
        tests_run++;
        if ({bus.p_left, bus.p_right, bus.p_flap, bus.start1, bus.start2, bus.pause} !== 9'd0) begin
            tests_failed++;
            $display("[TB] FAIL midpulse_outputs got %b want 0",
                     {bus.p_left, bus.p_right, bus.p_flap, bus.start1, bus.start2, bus.pause});
        end
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp = (k >= 5) && (k <= 14);
            tests_run++;
            if (bus.coin !== exp) begin
                tests_failed++;
                $display("[TB] FAIL coin_after_reset cycle %0d got %b want %b", k, bus.coin, exp);
            end
        end
    endtask

    task automatic test_autofire;
        logic exp;
        clear_inputs(8);
        bus.joy_in[9] = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick(1);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            exp = (k >= 5) && ((((k - 5) / 8) % 2) == 0);
`else
            exp = 1'b0;
`endif
            tests_run++;
            if (bus.p_flap[0] !== exp) begin
                tests_failed++;
                $display("[TB] FAIL autofire cycle %0d got %b want %b", k, bus.p_flap[0], exp);
            end
        end
    endtask

    // Runs every scenario in order, then prints the summary
    initial begin
        bus.joy_in     = '0;
        bus.share_mode = 1'b0;
        bus.swap_12    = 1'b0;
        test_reset();
        test_debounce();
        test_global_buttons();
        test_routing();
        test_cancel();
        test_coin();
        test_reset_mid_pulse();
        test_autofire();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
